// File: rtl/seq_debounce_edge_1b.sv
`default_nettype none
// ============================================================================
// Module      : seq_debounce_edge_1b
// Description : 1-bit input debouncer. Turns a noisy level input into a clean
//               registered level that changes only after STABLE_CYCLES
//               consecutive samples of the new level. Also produces one-cycle
//               rise/fall pulses and a saturating count of aborted transitions.
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   reset_ni       synchronous active-low reset (0 = reset)
//   in_i           raw input level
//   out_o          debounced level (registered)
//   rise_o         one-cycle pulse after out_o goes 0->1
//   fall_o         one-cycle pulse after out_o goes 1->0
//   glitch_cnt_o   saturating count of aborted transitions
//
// Configuration macro
//   DEBOUNCE_SYNC_EN  when defined, in_i passes through a 2-flop synchronizer
//                     (reset to 0) before the filter; every latency grows by 2.
//
// Revision    : 1.0  initial release
// ============================================================================
module seq_debounce_edge_1b #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                in_i,
    output logic                out_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_q, out_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic [GLITCH_W-1:0]   glitch_q, glitch_d;
    logic                  glitch_inc;
    logic                  samp;

    // ------------------------------------------------------------------------
    // Sample source
    // ------------------------------------------------------------------------
`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], in_i};
        end
    end

    assign samp = sync_q[1];
`else
    assign samp = in_i;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= LO;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // cnt holds the number of consecutive samples of the candidate level seen
    // so far; the transition completes on the sample that would make it
    // STABLE_CYCLES, so cnt itself never exceeds STABLE_CYCLES-1.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_d   = glitch_q;
        glitch_inc = 1'b0;

        case (state_q)
            LO: begin
                if (samp) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!samp) begin
                    state_d    = LO;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HI;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HI: begin
                if (!samp) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (samp) begin
                    state_d    = HI;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LO;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LO;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase

        // Saturate rather than wrap so a long burst of noise stays visible.
        if (glitch_inc && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    assign out_o        = out_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign glitch_cnt_o = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_debounce_edge_1b.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_debounce_edge_1b
// Description : Self-checking bench for seq_debounce_edge_1b. Two instances
//               (GLITCH_W=8 and GLITCH_W=2) share stimulus; outputs are
//               compared with a run-length reference model after each edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_debounce_edge_1b;

    localparam int STABLE = 4;

    logic       clk;
    logic       reset_ni;
    logic       in_i;
    logic       out_a, rise_a, fall_a;
    logic [7:0] gl_a;
    logic       out_b, rise_b, fall_b;
    logic [1:0] gl_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: current clean level, length of the current run of
    // samples that differ from it, and an unbounded glitch tally.
    logic m_out, m_rise, m_fall;
    int   m_run, m_gl;

    seq_debounce_edge_1b #(.STABLE_CYCLES(STABLE), .CNT_W(3), .GLITCH_W(8)) u_dut_a (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .in_i         (in_i),
        .out_o        (out_a),
        .rise_o       (rise_a),
        .fall_o       (fall_a),
        .glitch_cnt_o (gl_a)
    );

    seq_debounce_edge_1b #(.STABLE_CYCLES(STABLE), .CNT_W(3), .GLITCH_W(2)) u_dut_b (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .in_i         (in_i),
        .out_o        (out_b),
        .rise_o       (rise_b),
        .fall_o       (fall_b),
        .glitch_cnt_o (gl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Apply one cycle of stimulus, advance the model, then check both DUTs.
    task automatic step(input logic r, input logic i);
        reset_ni = r;
        in_i     = i;
        @(posedge clk);
        if (!r) begin
            m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_gl = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (i != m_out) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_out  = i;
                    m_rise = i;
                    m_fall = ~i;
                    m_run  = 0;
                end
            end else begin
                if (m_run > 0) m_gl++;
                m_run = 0;
            end
        end
        #1;
        chk("out",    {31'd0, out_a},  {31'd0, m_out});
        chk("rise",   {31'd0, rise_a}, {31'd0, m_rise});
        chk("fall",   {31'd0, fall_a}, {31'd0, m_fall});
        chk("glitch", {24'd0, gl_a},   sat(m_gl, 255));
        chk("out_w2", {31'd0, out_b},  {31'd0, m_out});
        chk("rf_w2",  {30'd0, rise_b, fall_b}, {30'd0, m_rise, m_fall});
        chk("gl_w2",  {30'd0, gl_b},   sat(m_gl, 3));
        chk("excl",   {31'd0, rise_a & fall_a}, 32'd0);
    endtask

    initial begin
        logic cur;
        m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_gl = 0;
        reset_ni = 1'b0;
        in_i     = 1'b1;

        // Reset held with in high
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_out", {31'd0, out_a}, 32'd0);
        chk("rst_gl",  {24'd0, gl_a},  32'd0);

        // Rise after four high samples
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("pre_rise_out", {31'd0, out_a}, 32'd0);
        step(1'b1, 1'b1);
        chk("rise_out", {31'd0, out_a},  32'd1);
        chk("rise_pls", {31'd0, rise_a}, 32'd1);
        step(1'b1, 1'b1);
        chk("rise_end", {31'd0, rise_a}, 32'd0);

        // Fall after four low samples
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        chk("fall_pls", {31'd0, fall_a}, 32'd1);
        chk("fall_out", {31'd0, out_a},  32'd0);
        step(1'b1, 1'b0);
        chk("fall_end", {31'd0, fall_a}, 32'd0);

        // Abort then successful rise: 1,1,0,1,1,1,1
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("abort_gl", {24'd0, gl_a}, 32'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        chk("abort_mid", {31'd0, out_a}, 32'd0);
        step(1'b1, 1'b1);
        chk("abort_rise", {31'd0, rise_a}, 32'd1);

        // Reset in the middle of a check is not a glitch
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_mid_gl",  {24'd0, gl_a},  32'd0);
        chk("rst_mid_out", {31'd0, out_a}, 32'd0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        chk("rst_mid_hold", {31'd0, out_a}, 32'd0);
        step(1'b1, 1'b1);
        chk("rst_mid_rise", {31'd0, out_a}, 32'd1);

        // Glitch counter saturation on the 2-bit instance
        step(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        chk("sat_w2", {30'd0, gl_b}, 32'd3);
        chk("sat_w8", {24'd0, gl_a}, 32'd5);

        // Random run: occasional resets, input that tends to persist
        cur = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) cur = ~cur;
            step(($urandom_range(0, 24) != 0), cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
